// File: rtl/lsu_mem_stage.sv
// Load/store stage sitting after the ALU. Runs one data-memory transaction
// at a time over a req/ready bus, aligns store lanes, extracts and extends
// load data, and reports misaligned-access and bus-fault status.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_misaligned,
  output logic        out_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rd;

  logic        acc_illegal;
  logic        acc_misaligned;
  logic [3:0]  acc_wstrb;
  logic [31:0] acc_wdata;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;

  // The stage only takes a new access when idle.
  assign in_ready = (state == S_IDLE);

  // Classify the incoming access and build its byte lanes for the bus.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    acc_illegal    = (in_size == 2'b11);
    acc_misaligned = 1'b0;
    acc_wstrb      = 4'b0000;
    acc_wdata      = 32'h0;
    case (in_size)
      SIZE_BYTE: begin
        acc_wstrb = 4'b0001 << in_addr[1:0];
        acc_wdata = {4{in_wdata[7:0]}};
      end
      SIZE_HALF: begin
        acc_misaligned = in_addr[0];
        acc_wstrb      = 4'b0011 << in_addr[1:0];
        acc_wdata      = {2{in_wdata[15:0]}};
      end
      SIZE_WORD: begin
        acc_misaligned = (in_addr[1:0] != 2'b00);
        acc_wstrb      = 4'b1111;
        acc_wdata      = in_wdata;
      end
      default: ;
    endcase
    if (!in_we) begin
      acc_wstrb = 4'b0000;
      acc_wdata = 32'h0;
    end
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    rd_shifted = mem_rdata >> {r_addr_lo, 3'b000};
    case (r_size)
      SIZE_BYTE: load_ext = {{24{~r_unsigned & rd_shifted[7]}},  rd_shifted[7:0]};
      SIZE_HALF: load_ext = {{16{~r_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
      default:   load_ext = mem_rdata;
    endcase
  end

  // Access sequencer: IDLE accepts, REQ holds the bus, RESP pulses the result.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update order-independent.
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= 16'h0;
      r_we           <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_addr_lo      <= 2'b00;
      r_rd           <= 5'h0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 32'h0;
      mem_wstrb      <= 4'h0;
      mem_wdata      <= 32'h0;
      out_valid      <= 1'b0;
      out_rdata      <= 32'h0;
      out_rd         <= 5'h0;
      out_misaligned <= 1'b0;
      out_fault      <= 1'b0;
    end else begin
      // Completion outputs are a single-cycle pulse unless set below.
      out_valid      <= 1'b0;
      out_rdata      <= 32'h0;
      out_rd         <= 5'h0;
      out_misaligned <= 1'b0;
      out_fault      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r_we       <= in_we;
            r_size     <= in_size;
            r_unsigned <= in_unsigned;
            r_addr_lo  <= in_addr[1:0];
            r_rd       <= in_rd;
            if (acc_illegal || acc_misaligned) begin
              state          <= S_RESP;
              out_valid      <= 1'b1;
              out_rd         <= in_rd;
              out_fault      <= acc_illegal;
              out_misaligned <= ~acc_illegal;
            end else begin
              state     <= S_REQ;
              cnt       <= 16'h0;
              mem_req   <= 1'b1;
              mem_we    <= in_we;
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_wstrb <= acc_wstrb;
              mem_wdata <= acc_wdata;
            end
          end
        end
        S_REQ: begin
          if (mem_ready || (cnt == CNT_LAST)) begin
            state     <= S_RESP;
            out_valid <= 1'b1;
            out_rd    <= r_rd;
            out_fault <= ~mem_ready;
            out_rdata <= (mem_ready && !r_we) ? load_ext : 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store stage directly downstream of the ALU in the rv32i core. It takes the ALU result as the effective address plus the store data and access size. It runs one data-memory transaction over a req/ready bus and returns the sign- or zero-extended load data, or a misalign/fault status, to writeback. It processes one access at a time; the core stalls while in_ready=0.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ without mem_ready before bus fault (1..65535)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  access request from ALU stage
in_ready  out  1  stage can accept (high only in IDLE)
in_we  in  1  1=store, 0=load
in_size  in  2  00 byte, 01 half, 10 word, 11 illegal
in_unsigned  in  1  zero-extend load (LBU/LHU)
in_addr  in  32  effective address (ALU result)
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register tag
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  32  word-aligned address {in_addr[31:2],2'b00}
mem_wstrb  out  4  byte enables
mem_wdata  out  32  lane-aligned store data
mem_ready  in  1  bus completes the access this cycle
mem_rdata  in  32  read word, valid when mem_ready=1
out_valid  out  1  one-cycle completion pulse
out_rdata  out  32  extended load data (0 for stores and errors)
out_rd  out  5  tag of the completed access
out_misaligned  out  1  address misaligned, qualified by out_valid
out_fault  out  1  timeout or illegal size, qualified by out_valid

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, timeout counter=0. All outputs 0 except in_ready=1. Applies mid-transaction: mem_req drops at that edge and no out_valid is issued for the aborted access.
- States: IDLE, REQ, RESP.
- IDLE, in_valid=1: capture all in_* fields. Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to RESP with the matching error flag set. No bus request is issued. Otherwise go to REQ.
- REQ: mem_req=1. mem_we, mem_addr, mem_wstrb, mem_wdata stay stable until mem_ready=1 is sampled. On mem_ready: capture mem_rdata, go to RESP. The counter increments each REQ cycle without ready. When count==TIMEOUT_CYCLES-1 and mem_ready=0: drop the request, set out_fault, go to RESP. If mem_ready=1 on that same cycle, the access completes normally with no fault.
- RESP: out_valid=1 for exactly one cycle with out_rd, out_rdata and flags, then return to IDLE. in_ready=0 in REQ and RESP.
- Latency: accept edge T. mem_req is visible during cycle T+1; with mem_ready=1 in that cycle, out_valid is high in cycle T+2. Misaligned/illegal: out_valid is high in cycle T+1. Back-to-back throughput is one access per 3 cycles minimum.
- Store lanes, with o=addr[1:0]:
  - byte: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}
  - half: wstrb=4'b0011<<o, wdata={2{wdata[15:0]}}
  - word: wstrb=4'b1111, wdata unchanged
- Loads: wstrb=0, wdata=0.
- Load extract: byte = rdata[8*o+7:8*o], half = rdata[8*o+15:8*o]. Extend by bit 7/15 unless in_unsigned=1. Word returns rdata unchanged; in_unsigned is ignored for word.
- Stores report out_rdata=0. Error flags are 0 when out_valid=0.

Test Plan:
- Reset held 3 cycles during REQ -> mem_req=0 after the first reset edge; no out_valid; in_ready=1 once rst_n=1.
- LB addr 0x1003, mem_rdata 0x80AA5511, ready on the first REQ cycle -> mem_addr 0x1000; out_rdata 0xFFFFFF80 two cycles after accept. LBU, same case -> 0x00000080.
- SH addr 0x2002, wdata 0x1234ABCD -> mem_we=1, wstrb 4'b1100, mem_wdata 0xABCDABCD; out_valid with out_rdata 0.
- LW addr 0x3001 -> no mem_req; out_valid next cycle with out_misaligned=1, out_rdata 0, out_rd echoed.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then out_valid with out_fault=1. Rerun with ready on the 4th cycle -> normal completion, out_fault=0.
- mem_ready delayed 5 cycles, in_valid held high throughout -> mem_addr/wstrb/wdata stable while mem_req=1; in_ready=0 until the RESP cycle ends; the second request is accepted only after return to IDLE.
